req_page_splitter: RTL

- Stage directly downstream of the PMTU request parser, upstream of TLB lookup.
- Parsed chunks are at most PMTU bytes but are not address-aligned, so one chunk can straddle a page.
- This block splits every request at page boundaries, so each emitted request touches exactly one page.
- All other request fields pass through unchanged.

---
 rtl/req_page_splitter_pkg.sv | 87 ++++++++
 rtl/req_page_splitter_if.sv | 11 +
 rtl/req_page_splitter_calc.sv | 40 ++++
 rtl/req_page_splitter.sv | 113 +++++++++++
 4 files changed

// File: rtl/req_page_splitter_pkg.sv
// Shared request types and widths for the page splitter and its neighbours.
package req_page_splitter_pkg;

  // Default log2 page size (4 KiB pages)
  localparam int PG_BITS_DEF    = 12;

  // Request field widths
  localparam int OPCODE_BITS    = 5;
  localparam int VADDR_BITS     = 48;
  localparam int LEN_BITS       = 28;
  localparam int PID_BITS       = 6;
  localparam int N_REGIONS_BITS = 1;
  localparam int DEST_BITS      = 4;
  localparam int STRM_BITS      = 2;
  localparam int OFFS_BITS      = 6;

  typedef struct packed {
    logic [OPCODE_BITS-1:0]    opcode;
    logic                      mode;
    logic                      rdma;
    logic                      remote;
    logic [VADDR_BITS-1:0]     vaddr;
    logic [LEN_BITS-1:0]       len;
    logic                      last;
    logic [PID_BITS-1:0]       pid;
    logic [N_REGIONS_BITS-1:0] vfid;
    logic [DEST_BITS-1:0]      dest;
    logic [STRM_BITS-1:0]      strm;
    logic                      host;
    logic                      actv;
    logic [OFFS_BITS-1:0]      offs;
  } req_t;

  // Everything in a request that is copied unchanged onto every chunk
  typedef struct packed {
    logic [OPCODE_BITS-1:0]    opcode;
    logic                      mode;
    logic                      rdma;
    logic                      remote;
    logic [PID_BITS-1:0]       pid;
    logic [N_REGIONS_BITS-1:0] vfid;
    logic [DEST_BITS-1:0]      dest;
    logic [STRM_BITS-1:0]      strm;
    logic                      host;
    logic                      actv;
    logic [OFFS_BITS-1:0]      offs;
  } hdr_t;

  function automatic hdr_t get_hdr(input req_t r);
    hdr_t h;
    h.opcode = r.opcode;
    h.mode   = r.mode;
    h.rdma   = r.rdma;
    h.remote = r.remote;
    h.pid    = r.pid;
    h.vfid   = r.vfid;
    h.dest   = r.dest;
    h.strm   = r.strm;
    h.host   = r.host;
    h.actv   = r.actv;
    h.offs   = r.offs;
    return h;
  endfunction

  function automatic req_t build_req(input hdr_t h,
                                     input logic [VADDR_BITS-1:0] vaddr,
                                     input logic [LEN_BITS-1:0] len,
                                     input logic last);
    req_t r;
    r.opcode = h.opcode;
    r.mode   = h.mode;
    r.rdma   = h.rdma;
    r.remote = h.remote;
    r.vaddr  = vaddr;
    r.len    = len;
    r.last   = last;
    r.pid    = h.pid;
    r.vfid   = h.vfid;
    r.dest   = h.dest;
    r.strm   = h.strm;
    r.host   = h.host;
    r.actv   = h.actv;
    r.offs   = h.offs;
    return r;
  endfunction

endpackage

// File: rtl/req_page_splitter_if.sv
// Valid/ready request channel carrying one req_t per beat.
interface metaIntf;
  import req_page_splitter_pkg::*;

  logic valid;
  logic ready;
  req_t data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);
endinterface

// File: rtl/req_page_splitter_calc.sv
// Combinational chunk calculator: carves the next page-bounded piece off the
// remaining request and reports what is left over.
module req_page_calc
  import req_page_splitter_pkg::*;
#(
  parameter int PG_BITS = PG_BITS_DEF
) (
  input  logic [VADDR_BITS-1:0] cur_vaddr_i,
  input  logic [LEN_BITS-1:0]   rem_len_i,
  output logic [LEN_BITS-1:0]   o_len_o,
  output logic [LEN_BITS-1:0]   rem_len_nxt_o,
  output logic [VADDR_BITS-1:0] cur_vaddr_nxt_o,
  output logic                  is_final_o
);

  localparam logic [PG_BITS:0] PG_SIZE = {1'b1, {PG_BITS{1'b0}}};

  // Bytes from cur_vaddr to the next page boundary: 1..PG_SIZE
  logic [PG_BITS:0]   btb;
  logic [LEN_BITS-1:0] btb_ext;

  assign btb     = PG_SIZE - {1'b0, cur_vaddr_i[PG_BITS-1:0]};
  assign btb_ext = LEN_BITS'(btb);

  // Take the rest of the page, or everything left if it fits; the address
  // advance wraps silently at the top of the virtual address space
  always_comb begin
    o_len_o         = rem_len_i;
    rem_len_nxt_o   = '0;
    cur_vaddr_nxt_o = cur_vaddr_i;
    is_final_o      = 1'b1;
    if (rem_len_i > btb_ext) begin
      o_len_o         = btb_ext;
      rem_len_nxt_o   = rem_len_i - btb_ext;
      cur_vaddr_nxt_o = cur_vaddr_i + VADDR_BITS'(btb);
      is_final_o      = 1'b0;
    end
  end

endmodule

// File: rtl/req_page_splitter.sv
// Splits each incoming request at page boundaries so every emitted request
// touches exactly one page. Handshake outputs are registered, so m_req.ready
// never reaches s_req.ready or m_req.data combinationally.
module req_page_splitter
  import req_page_splitter_pkg::*;
#(
  parameter int PG_BITS = PG_BITS_DEF
) (
  input  logic aclk,
  input  logic aresetn,
  metaIntf.s   s_req,
  metaIntf.m   m_req
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SEND
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_q, valid_q;
  hdr_t                  hdr_q, hdr_d;
  logic                  last_q, last_d;
  logic [LEN_BITS-1:0]   rem_len_q, rem_len_d;
  logic [VADDR_BITS-1:0] cur_vaddr_q, cur_vaddr_d;
  logic [VADDR_BITS-1:0] o_vaddr_q, o_vaddr_d;
  logic [LEN_BITS-1:0]   o_len_q, o_len_d;
  logic                  o_last_q, o_last_d;

  logic [LEN_BITS-1:0]   calc_len;
  logic [LEN_BITS-1:0]   calc_rem;
  logic [VADDR_BITS-1:0] calc_vaddr;
  logic                  calc_final;

  req_page_calc #(
    .PG_BITS (PG_BITS)
  ) u_calc (
    .cur_vaddr_i     (cur_vaddr_q),
    .rem_len_i       (rem_len_q),
    .o_len_o         (calc_len),
    .rem_len_nxt_o   (calc_rem),
    .cur_vaddr_nxt_o (calc_vaddr),
    .is_final_o      (calc_final)
  );

  // Next-state and datapath updates for accept / calculate / send
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    last_d      = last_q;
    rem_len_d   = rem_len_q;
    cur_vaddr_d = cur_vaddr_q;
    o_vaddr_d   = o_vaddr_q;
    o_len_d     = o_len_q;
    o_last_d    = o_last_q;
    case (state_q)
      ST_IDLE: begin
        // ready_q is low for one cycle after reset release even in ST_IDLE
        if (s_req.valid && ready_q) begin
          hdr_d       = get_hdr(s_req.data);
          last_d      = s_req.data.last;
          rem_len_d   = s_req.data.len;
          cur_vaddr_d = s_req.data.vaddr;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        o_vaddr_d   = cur_vaddr_q;
        o_len_d     = calc_len;
        o_last_d    = calc_final ? last_q : 1'b0;
        rem_len_d   = calc_rem;
        cur_vaddr_d = calc_vaddr;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (m_req.ready) begin
          state_d = (rem_len_q != '0) ? ST_CALC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and registered handshake flags, cleared asynchronously
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      valid_q <= (state_d == ST_SEND);
    end
  end

  // Datapath registers need no reset; they are always written before use
  always_ff @(posedge aclk) begin
    hdr_q       <= hdr_d;
    last_q      <= last_d;
    rem_len_q   <= rem_len_d;
    cur_vaddr_q <= cur_vaddr_d;
    o_vaddr_q   <= o_vaddr_d;
    o_len_q     <= o_len_d;
    o_last_q    <= o_last_d;
  end

  assign s_req.ready = ready_q;
  assign m_req.valid = valid_q;
  assign m_req.data  = build_req(hdr_q, o_vaddr_q, o_len_q, o_last_q);

endmodule
